lfsr_gen: RTL and testbench



---
 rtl/lfsr_pkg.sv | 82 ++++++++
 rtl/lfsr_step.sv | 14 +
 rtl/lfsr_gen.sv | 101 ++++++++++
 tb/tb_lfsr_gen.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared constants and helpers for the Galois LFSR generator family.
// Feedback masks are for right-shift Galois form: bit k-1 set for each x^k term.
package lfsr_pkg;

  localparam logic [3:0]  TAPS4  = 4'hC;
  localparam logic [4:0]  TAPS5  = 5'h14;
  localparam logic [5:0]  TAPS6  = 6'h30;
  localparam logic [6:0]  TAPS7  = 7'h60;
  localparam logic [7:0]  TAPS8  = 8'hB8;
  localparam logic [8:0]  TAPS9  = 9'h110;
  localparam logic [9:0]  TAPS10 = 10'h240;
  localparam logic [10:0] TAPS11 = 11'h500;
  localparam logic [11:0] TAPS12 = 12'hE08;
  localparam logic [12:0] TAPS13 = 13'h1C80;
  localparam logic [13:0] TAPS14 = 14'h3802;
  localparam logic [14:0] TAPS15 = 15'h6000;
  localparam logic [15:0] TAPS16 = 16'hB400;
  localparam logic [16:0] TAPS17 = 17'h12000;
  localparam logic [17:0] TAPS18 = 18'h20400;
  localparam logic [18:0] TAPS19 = 19'h72000;
  localparam logic [19:0] TAPS20 = 20'h90000;
  localparam logic [20:0] TAPS21 = 21'h140000;
  localparam logic [21:0] TAPS22 = 22'h300000;
  localparam logic [22:0] TAPS23 = 23'h420000;
  localparam logic [23:0] TAPS24 = 24'hE10000;
  localparam logic [24:0] TAPS25 = 25'h1200000;
  localparam logic [25:0] TAPS26 = 26'h2000023;
  localparam logic [26:0] TAPS27 = 27'h4000013;
  localparam logic [27:0] TAPS28 = 28'h9000000;
  localparam logic [28:0] TAPS29 = 29'h14000000;
  localparam logic [29:0] TAPS30 = 30'h20000029;
  localparam logic [30:0] TAPS31 = 31'h48000000;
  localparam logic [31:0] TAPS32 = 32'h80200003;

  localparam logic [15:0] SEED16 = 16'hACE1;
  localparam logic [31:0] SEED32 = 32'hACE1_2D47;

  // Maximal-length mask for a given width, zero-extended to 32 bits.
  function automatic logic [31:0] default_taps(input int width);
    case (width)
      4:  return 32'(TAPS4);
      5:  return 32'(TAPS5);
      6:  return 32'(TAPS6);
      7:  return 32'(TAPS7);
      8:  return 32'(TAPS8);
      9:  return 32'(TAPS9);
      10: return 32'(TAPS10);
      11: return 32'(TAPS11);
      12: return 32'(TAPS12);
      13: return 32'(TAPS13);
      14: return 32'(TAPS14);
      15: return 32'(TAPS15);
      16: return 32'(TAPS16);
      17: return 32'(TAPS17);
      18: return 32'(TAPS18);
      19: return 32'(TAPS19);
      20: return 32'(TAPS20);
      21: return 32'(TAPS21);
      22: return 32'(TAPS22);
      23: return 32'(TAPS23);
      24: return 32'(TAPS24);
      25: return 32'(TAPS25);
      26: return 32'(TAPS26);
      27: return 32'(TAPS27);
      28: return 32'(TAPS28);
      29: return 32'(TAPS29);
      30: return 32'(TAPS30);
      31: return 32'(TAPS31);
      32: return TAPS32;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] s,
                                            input logic [31:0] taps,
                                            input int width);
    logic [31:0] mask;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return ((s >> 1) ^ (s[0] ? taps : 32'h0)) & mask;
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// One combinational right-shift Galois LFSR step.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int              WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS = TAPS16
) (
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt
);

  assign nxt = {1'b0, cur[WIDTH-1:1]} ^ (cur[0] ? TAPS : '0);

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised Galois LFSR source with step counter, wrap and lockup flags.
// Optional macro LFSR_LOCKUP_RECOVER_EN: zero loads are replaced by SEED.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = TAPS16,
  parameter logic [WIDTH-1:0] SEED  = SEED16,
  parameter int               STEP  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] lfsr_out,
  output logic [WIDTH-1:0] step_cnt,
  output logic             wrap,
  output logic             lockup
);

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             lockup_q, lockup_d;
  logic [STEP:0][WIDTH-1:0] chain;
  logic [WIDTH-1:0] stepped;

  assign chain[0] = state_q;

  for (genvar g = 0; g < STEP; g++) begin : g_step
    lfsr_step #(
      .WIDTH(WIDTH),
      .TAPS (TAPS)
    ) u_step (
      .cur(chain[g]),
      .nxt(chain[g+1])
    );
  end

  assign stepped = chain[STEP];

  always_comb begin
    state_d  = state_q;
    ref_d    = ref_q;
    cnt_d    = cnt_q;
    wrap_d   = 1'b0;
    lockup_d = 1'b0;
    if (load) begin
      cnt_d = '0;
`ifdef LFSR_LOCKUP_RECOVER_EN
      if (load_val == '0) begin
        state_d  = SEED;
        ref_d    = SEED;
        lockup_d = 1'b1;
      end else begin
        state_d = load_val;
        ref_d   = load_val;
      end
`else
      state_d = load_val;
      ref_d   = load_val;
`endif
    end else if (en) begin
      state_d = stepped;
      // Period is measured against the last reset/load value, not SEED.
      if (stepped == ref_q) begin
        wrap_d = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end
`ifndef LFSR_LOCKUP_RECOVER_EN
    lockup_d = (state_d == '0);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= SEED;
      ref_q    <= SEED;
      cnt_q    <= '0;
      wrap_q   <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ref_q    <= ref_d;
      cnt_q    <= cnt_d;
      wrap_q   <= wrap_d;
      lockup_q <= lockup_d;
    end
  end

  assign lfsr_out = state_q;
  assign step_cnt = cnt_q;
  assign wrap     = wrap_q;
  assign lockup   = lockup_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Scoreboard bench for lfsr_gen: STEP=1 and STEP=2 instances share stimulus.
module tb_lfsr_gen;

  localparam logic [15:0] P_TAPS = 16'hB400;
  localparam logic [15:0] P_SEED = 16'hACE1;

  typedef struct {
    logic [15:0] s;
    logic [15:0] c;
    logic        w;
    logic        l;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_val = 16'h0;

  logic [15:0] out0, cnt0, out1, cnt1;
  logic        wrap0, lock0, wrap1, lock1;

  lfsr_gen dut0 (
    .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
    .lfsr_out(out0), .step_cnt(cnt0), .wrap(wrap0), .lockup(lock0)
  );

  lfsr_gen #(.STEP(2)) dut1 (
    .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
    .lfsr_out(out1), .step_cnt(cnt1), .wrap(wrap1), .lockup(lock1)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: state held as a plain value, advanced by the polynomial rule.
  logic [15:0] m_s [2];
  logic [15:0] m_r [2];
  logic [15:0] m_c [2];
  logic        m_w [2];
  logic        m_l [2];
  int          m_step [2] = '{1, 2};
  exp_t        q0[$];
  exp_t        q1[$];

  function automatic logic [15:0] advance(input logic [15:0] s, input int n);
    logic [15:0] v;
    v = s;
    for (int k = 0; k < n; k++) v = v[0] ? ((v >> 1) ^ P_TAPS) : (v >> 1);
    return v;
  endfunction

  task automatic model(input int d, input logic r, input logic ld,
                       input logic [15:0] lv, input logic e);
    if (r) begin
      m_s[d] = P_SEED; m_r[d] = P_SEED; m_c[d] = 0; m_w[d] = 0; m_l[d] = 0;
    end else if (ld) begin
      m_c[d] = 0; m_w[d] = 0;
`ifdef LFSR_LOCKUP_RECOVER_EN
      m_s[d] = (lv == 0) ? P_SEED : lv;
      m_l[d] = (lv == 0);
`else
      m_s[d] = lv;
      m_l[d] = (lv == 0);
`endif
      m_r[d] = m_s[d];
    end else if (e) begin
      m_s[d] = advance(m_s[d], m_step[d]);
      m_w[d] = (m_s[d] == m_r[d]);
      m_c[d] = m_w[d] ? 16'd0 : m_c[d] + 16'd1;
`ifdef LFSR_LOCKUP_RECOVER_EN
      m_l[d] = 0;
`else
      m_l[d] = (m_s[d] == 0);
`endif
    end else begin
      m_w[d] = 0;
`ifdef LFSR_LOCKUP_RECOVER_EN
      m_l[d] = 0;
`else
      m_l[d] = (m_s[d] == 0);
`endif
    end
  endtask

  task automatic cycle(input logic r, input logic ld, input logic [15:0] lv, input logic e);
    exp_t x;
    reset = r; load = ld; load_val = lv; en = e;
    model(0, r, ld, lv, e);
    model(1, r, ld, lv, e);
    @(posedge clk);
    #1;
    x.s = m_s[0]; x.c = m_c[0]; x.w = m_w[0]; x.l = m_l[0];
    q0.push_back(x);
    x.s = m_s[1]; x.c = m_c[1]; x.w = m_w[1]; x.l = m_l[1];
    q1.push_back(x);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk("sb0_out", 32'(out0), 32'(e.s));
      chk("sb0_cnt", 32'(cnt0), 32'(e.c));
      chk("sb0_wrap", 32'(wrap0), 32'(e.w));
      chk("sb0_lockup", 32'(lock0), 32'(e.l));
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("sb1_out", 32'(out1), 32'(e.s));
      chk("sb1_cnt", 32'(cnt1), 32'(e.c));
      chk("sb1_wrap", 32'(wrap1), 32'(e.w));
      chk("sb1_lockup", 32'(lock1), 32'(e.l));
    end
  end

  initial begin
    int nwrap;
    // Reset and first steps
    cycle(1, 0, 16'h0, 0);
    cycle(1, 0, 16'h0, 0);
    chk("rst_out", 32'(out0), 32'hACE1);
    chk("rst_cnt", 32'(cnt0), 32'h0);
    chk("rst_wrap", 32'(wrap0), 32'h0);
    chk("rst_lockup", 32'(lock0), 32'h0);
    cycle(0, 0, 16'h0, 1);
    chk("seq1", 32'(out0), 32'hE270);
    chk("seq1_cnt", 32'(cnt0), 32'd1);
    // Hold from E270
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 16'h0, 0);
      chk("hold_out", 32'(out0), 32'hE270);
      chk("hold_cnt", 32'(cnt0), 32'd1);
      chk("hold_wrap", 32'(wrap0), 32'h0);
    end
    cycle(0, 0, 16'h0, 1);
    chk("seq2", 32'(out0), 32'h7138);
    cycle(0, 0, 16'h0, 1);
    chk("seq3", 32'(out0), 32'h389C);
    chk("seq3_cnt", 32'(cnt0), 32'd3);
    // Load wins over en
    cycle(0, 1, 16'h0001, 1);
    chk("load_out", 32'(out0), 32'h0001);
    chk("load_cnt", 32'(cnt0), 32'h0);
    cycle(0, 0, 16'h0, 1);
    chk("load_step", 32'(out0), 32'hB400);
    // Zero load
    cycle(0, 1, 16'h0000, 0);
`ifdef LFSR_LOCKUP_RECOVER_EN
    chk("zload_out", 32'(out0), 32'hACE1);
    chk("zload_lockup", 32'(lock0), 32'h1);
    cycle(0, 0, 16'h0, 1);
    chk("zload_lockup_pulse", 32'(lock0), 32'h0);
`else
    chk("zload_out", 32'(out0), 32'h0);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 16'h0, 1);
      chk("zero_out", 32'(out0), 32'h0);
      chk("zero_lockup", 32'(lock0), 32'h1);
      chk("zero_wrap", 32'(wrap0), 32'h1);
      chk("zero_cnt", 32'(cnt0), 32'h0);
    end
    cycle(0, 1, 16'h0001, 0);
    chk("unlock", 32'(lock0), 32'h0);
`endif
    // STEP=2 instance, with mid-run reset
    cycle(1, 0, 16'h0, 0);
    chk("s2_rst", 32'(out1), 32'hACE1);
    cycle(0, 0, 16'h0, 1);
    chk("s2_first", 32'(out1), 32'h7138);
    chk("s2_cnt", 32'(cnt1), 32'd1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 16'h0, 1);
    cycle(1, 1, 16'h1234, 1);
    chk("s2_midrst_out", 32'(out1), 32'hACE1);
    chk("s2_midrst_cnt", 32'(cnt1), 32'h0);
    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      logic r, ld, e;
      logic [15:0] lv;
      r  = ($urandom_range(99) == 0);
      ld = ($urandom_range(19) == 0);
      lv = ($urandom_range(3) == 0) ? 16'h0 : 16'($urandom);
      e  = ($urandom_range(9) < 7);
      cycle(r, ld, lv, e);
    end
    // Full period from reset
    cycle(1, 0, 16'h0, 0);
    nwrap = 0;
    for (int i = 0; i < 65535; i++) begin
      cycle(0, 0, 16'h0, 1);
      if (wrap0) nwrap++;
      if (i == 65534) begin
        chk("period_out", 32'(out0), 32'hACE1);
        chk("period_cnt", 32'(cnt0), 32'h0);
        chk("period_wrap", 32'(wrap0), 32'h1);
      end
    end
    chk("period_wraps", 32'(nwrap), 32'd1);
    // Drain scoreboard with a bounded wait
    for (int i = 0; i < 5 && (q0.size() + q1.size()) > 0; i++) @(negedge clk);
    #1;
    chk("sb_drain", 32'(q0.size() + q1.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
